// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared widths and FSM encoding for the AES stream sequencer
package aes_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_WORD_W = 32;
  localparam int AES_WORDS  = 4;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2,
    DRAIN   = 2'd3
  } aes_state_t;

endpackage

// File: rtl/aes_word_shifter.sv
// rtl/aes_word_shifter.sv - 128-bit register with parallel load and shift-left-by-one-word
module aes_word_shifter
  import aes_pkg::*;
#(
  parameter int WORDS = AES_WORDS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [AES_BLK_W-1:0]  load_data,
  input  logic                  shift,
  input  logic [AES_WORD_W-1:0] shift_in,
  output logic [AES_BLK_W-1:0]  data,
  output logic                  last
);

  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [CNT_W-1:0] count;

  // last marks the word whose shift completes the block
  assign last = (count == CNT_W'(WORDS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data  <= '0;
      count <= '0;
    end else if (load) begin
      data  <= load_data;
      count <= '0;
    end else if (shift) begin
      data  <= {data[AES_BLK_W-AES_WORD_W-1:0], shift_in};
      count <= last ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/aes_stream_sequencer.sv
// rtl/aes_stream_sequencer.sv - word-stream front/back end for an iterative AES-128 core
module aes_stream_sequencer
  import aes_pkg::*;
#(
  parameter int Nr    = 10,
  parameter int WORDS = AES_WORDS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AES_WORD_W-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [AES_BLK_W-1:0]  core_blk,
  output logic                  core_run,
  input  logic [AES_BLK_W-1:0]  core_res,
  output logic [AES_WORD_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int RND_W = $clog2(Nr + 1);

  aes_state_t         state;
  logic [RND_W-1:0]   rnd;
  logic               in_fire, in_last;
  logic               out_fire, out_last;
  logic [AES_BLK_W-1:0] res;
  logic               unused_res;

  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign out_data   = res[AES_BLK_W-1 -: AES_WORD_W];
  assign unused_res = ^res[AES_BLK_W-AES_WORD_W-1:0];

  aes_word_shifter #(.WORDS(WORDS)) u_in_shift (
    .clk       (clk),
    .reset     (reset),
    .load      (1'b0),
    .load_data ('0),
    .shift     (in_fire),
    .shift_in  (in_data),
    .data      (core_blk),
    .last      (in_last)
  );

  aes_word_shifter #(.WORDS(WORDS)) u_out_shift (
    .clk       (clk),
    .reset     (reset),
    .load      (state == CAPTURE),
    .load_data (core_res),
    .shift     (out_fire),
    .shift_in  ('0),
    .data      (res),
    .last      (out_last)
  );

  // core_run spans rnd = 0..Nr so the core sees Nr+1 uninterrupted cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LOAD;
      rnd       <= '0;
      in_ready  <= 1'b1;
      core_run  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_fire && in_last) begin
            state    <= RUN;
            in_ready <= 1'b0;
            core_run <= 1'b1;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (rnd == RND_W'(Nr)) begin
            rnd      <= '0;
            state    <= CAPTURE;
            core_run <= 1'b0;
          end else begin
            rnd <= rnd + RND_W'(1);
          end
        end
        CAPTURE: begin
          state     <= DRAIN;
          out_valid <= 1'b1;
        end
        DRAIN: begin
          if (out_fire && out_last) begin
            state     <= LOAD;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
